alu_secure_pipe: RTL and testbench
==================================

ALU_SECURE_PIPE -- requirements
Module: alu_secure_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 Parameter CNT_W, default 8, mismatch counter width.
REQ-003 Parameter LOCK_ON_ALARM, default 1; 1 = outputs squashed while alarm set.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 op  input  3  opcode.
REQ-011 inj_en  input  1  fault injection; flips primary-lane result bit 0 for the accepted operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 result  output  WIDTH  operation result.
REQ-015 carry, zero, overflow  output  1 each  flags.
REQ-016 alarm  output  1  sticky lane-mismatch flag.
REQ-017 alarm_clr  input  1  single-cycle pulse clears alarm and counter.
REQ-018 mismatch_cnt  output  CNT_W  saturating count of mismatching operations.

Function
REQ-019 Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by 1, 111 SHR A by 1 (logical).
REQ-020 ADD: carry = carry-out bit WIDTH; overflow = signed two's-complement overflow.
REQ-021 SUB: carry = 1 when A >= B unsigned (no borrow); overflow = signed overflow of A-B.
REQ-022 SHL: carry = A[WIDTH-1]; SHR: carry = A[0]; overflow = 0 for all non-arithmetic ops; carry = 0 for logic ops.
REQ-023 zero = 1 exactly when result equals 0.
REQ-024 Two-stage pipeline: S1 registers operands, op, inj_en; S2 registers primary result/flags and checker compare; latency is 2 cycles from acceptance to out_valid with out_ready held high.
REQ-025 Throughput of one operation per cycle when out_ready is held high.
REQ-026 S2 holds result stable while out_valid && !out_ready; S1 advances into S2 only when S2 is empty or being consumed in the same cycle.
REQ-027 in_ready = !S1_valid || S1 advancing; bubbles collapse; in_ready is combinational from out_ready only, never from in_valid.
REQ-028 Checker lane recomputes result and flags independently (SUB as A + ~B + 1; shifts via concatenation); injection never affects the checker lane.
REQ-029 Mismatch = any difference in result, carry, or overflow between lanes, evaluated once per operation on S1->S2 transfer.
REQ-030 On mismatch: alarm set next cycle; mismatch_cnt increments, saturating at all-ones.
REQ-031 alarm_clr and mismatch in the same cycle: mismatch wins; alarm = 1, counter = 1.
REQ-032 LOCK_ON_ALARM = 1 and alarm = 1: result, carry, zero, overflow driven 0; out_valid/out_ready handshake continues unchanged.
REQ-033 LOCK_ON_ALARM = 0: primary lane values always presented.

Reset
REQ-034 rst_n low: S1/S2 valid, out_valid, result, flags, alarm, mismatch_cnt all 0 immediately, independent of clk.
REQ-035 in_ready = 1 after reset; in-flight operations are discarded, not completed.
REQ-036 Reset release is synchronised by the integrator; the block takes no action on deassertion other than resuming on the next edge.

Structure
REQ-037 Opcode encodings and op enum live in shared package alu_secure_pkg.
REQ-038 One combinational sub-module alu_core (WIDTH-parameterised, A, B, op -> result, carry, overflow), instantiated once as the primary lane; the checker lane is written separately in alu_secure_pipe.

Verification
REQ-039 WIDTH=8, ADD 0xFF+0x01, out_ready=1 -> 2 cycles later result 0x00, carry 1, zero 1, overflow 0.
REQ-040 SUB 0x80-0x01 -> result 0x7F, carry 1, overflow 1; SUB 0x01-0x02 -> 0xFF, carry 0.
REQ-041 Back-to-back 4 ops with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 held ops, all 4 results emitted in order, none lost or duplicated.
REQ-042 AND 0x0F,0xF0 with inj_en=1 -> alarm 1, mismatch_cnt 1, result 0x00 (locked); next clean op also returns 0x00 flags 0.
REQ-043 alarm_clr pulse -> alarm 0, cnt 0; subsequent clean XOR 0xAA,0x55 -> result 0xFF.
REQ-044 rst_n asserted with both stages full -> out_valid 0 same cycle, no result emitted after release; 256 injected ops -> mismatch_cnt saturates at 0xFF.

Source files
------------

// File: rtl/alu_secure_pkg.sv
// Shared opcode definitions for the dual-lane secure ALU pipeline.
package alu_secure_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;
endpackage

// File: rtl/alu_core.sv
// Primary-lane combinational ALU: result plus carry/overflow flags.
module alu_core
  import alu_secure_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Borrow out of the extended subtract is the inverse of "no borrow".
        result   = diff_ext[WIDTH-1:0];
        carry    = ~diff_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = a << 1;
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = a >> 1;
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_secure_pipe.sv
// Two-stage ALU pipeline with an independent checker lane, sticky alarm,
// saturating mismatch counter and optional output lock while alarmed.
module alu_secure_pipe
  import alu_secure_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int CNT_W         = 8,
  parameter int LOCK_ON_ALARM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  op,
  input  logic             inj_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             alarm,
  input  logic             alarm_clr,
  output logic [CNT_W-1:0] mismatch_cnt
);
  localparam bit LOCK = (LOCK_ON_ALARM != 0);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OP_W-1:0]  op_q;
  logic             inj_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q;
  logic             carry_q, zero_q, ovf_q;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, accept, mismatch, lock;
  logic [WIDTH-1:0] pri_raw, pri_res;
  logic             pri_c, pri_v;
  logic [WIDTH-1:0] chk_res, chk_nb;
  logic             chk_c, chk_v;
  logic [WIDTH:0]   chk_add, chk_sub;

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_pri (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .result  (pri_raw),
    .carry   (pri_c),
    .overflow(pri_v)
  );

  assign pri_res = pri_raw ^ {{(WIDTH-1){1'b0}}, inj_q};

  // Checker lane uses a different formulation so a shared bug is unlikely.
  assign chk_nb  = ~b_q;
  assign chk_add = {1'b0, a_q} + {1'b0, b_q};
  assign chk_sub = {1'b0, a_q} + {1'b0, chk_nb} + (WIDTH+1)'(1);

  always_comb begin
    chk_res = '0;
    chk_c   = 1'b0;
    chk_v   = 1'b0;
    case (alu_op_e'(op_q))
      OP_ADD: begin
        chk_res = chk_add[WIDTH-1:0];
        chk_c   = chk_add[WIDTH];
        chk_v   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (chk_add[WIDTH-1] ^ a_q[WIDTH-1]);
      end
      OP_SUB: begin
        chk_res = chk_sub[WIDTH-1:0];
        chk_c   = chk_sub[WIDTH];
        chk_v   = (a_q[WIDTH-1] ~^ chk_nb[WIDTH-1]) & (chk_sub[WIDTH-1] ^ a_q[WIDTH-1]);
      end
      OP_AND: chk_res = a_q & b_q;
      OP_OR:  chk_res = a_q | b_q;
      OP_XOR: chk_res = a_q ^ b_q;
      OP_NOT: chk_res = ~a_q;
      OP_SHL: begin
        chk_res = {a_q[WIDTH-2:0], 1'b0};
        chk_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        chk_res = {1'b0, a_q[WIDTH-1:1]};
        chk_c   = a_q[0];
      end
      default: chk_res = '0;
    endcase
  end

  assign mismatch = s1_adv && ((pri_res != chk_res) || (pri_c != chk_c) || (pri_v != chk_v));

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    alarm_d    = alarm_q;
    cnt_d      = cnt_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s1_adv) s2_valid_d = 1'b1;
    else if (s2_valid_q && out_ready) s2_valid_d = 1'b0;
    // A fresh mismatch outranks a simultaneous clear.
    if (mismatch) begin
      alarm_d = 1'b1;
      if (alarm_clr) cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (alarm_clr) begin
      alarm_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      inj_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      alarm_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      alarm_q    <= alarm_d;
      cnt_q      <= cnt_d;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= op;
        inj_q <= inj_en;
      end
      if (s1_adv) begin
        res_q   <= pri_res;
        carry_q <= pri_c;
        zero_q  <= (pri_res == '0);
        ovf_q   <= pri_v;
      end
    end
  end

  assign lock         = LOCK && alarm_q;
  assign out_valid    = s2_valid_q;
  assign result       = lock ? '0 : res_q;
  assign carry        = lock ? 1'b0 : carry_q;
  assign zero         = lock ? 1'b0 : zero_q;
  assign overflow     = lock ? 1'b0 : ovf_q;
  assign alarm        = alarm_q;
  assign mismatch_cnt = cnt_q;
endmodule

// File: tb/tb_alu_secure_pipe.sv
// Self-checking bench: directed steps plus random traffic against an
// arithmetic reference model with an in-order scoreboard.
module tb_alu_secure_pipe;
  localparam int W  = 8;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2:0]    op = '0;
  logic          inj_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          carry, zero, overflow, alarm;
  logic          alarm_clr = 1'b0;
  logic [CW-1:0] mismatch_cnt;

  alu_secure_pipe #(.WIDTH(W), .CNT_W(CW), .LOCK_ON_ALARM(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .inj_en(inj_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .zero(zero),
    .overflow(overflow), .alarm(alarm), .alarm_clr(alarm_clr),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int c; int z; int v; bit inj;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int m_cnt = 0;
  bit m_alarm = 1'b0;
  logic          last_ov, last_c, last_z, last_v, last_alarm;
  logic [W-1:0]  last_res;
  logic [CW-1:0] last_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic exp_t model(input int a, input int b, input int o, input bit inj);
    exp_t e;
    int s;
    e.r = 0; e.c = 0; e.v = 0; e.inj = inj;
    case (o)
      0: begin
        s = a + b; e.r = s % 256; e.c = int'(s > 255);
        s = sgn(a) + sgn(b); e.v = int'(s > 127 || s < -128);
      end
      1: begin
        e.r = (a - b + 256) % 256; e.c = int'(a >= b);
        s = sgn(a) - sgn(b); e.v = int'(s > 127 || s < -128);
      end
      2: e.r = a & b;
      3: e.r = a | b;
      4: e.r = a ^ b;
      5: e.r = 255 - a;
      6: begin e.r = (a * 2) % 256; e.c = int'(a >= 128); end
      default: begin e.r = a / 2; e.c = a % 2; end
    endcase
    e.z = int'(e.r == 0);
    return e;
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, score, then take the edge.
  task automatic cycle(input bit iv, input int a, input int b, input int o,
                       input bit inj, input bit ordy, input bit clr, output bit acc);
    exp_t e;
    bit lk;
    @(negedge clk);
    in_valid = iv; A = a[W-1:0]; B = b[W-1:0]; op = o[2:0];
    inj_en = inj; out_ready = ordy; alarm_clr = clr;
    #1;
    acc = iv && (in_ready === 1'b1);
    last_ov = out_valid; last_res = result; last_c = carry; last_z = zero;
    last_v = overflow; last_alarm = alarm; last_cnt = mismatch_cnt;
    if (out_valid === 1'b1 && ordy) begin
      n_out++;
      if (sb.size() == 0) begin
        check("spurious_output", out_valid, 0);
      end else begin
        e = sb.pop_front();
        if (e.inj) begin
          m_alarm = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
        lk = m_alarm;
        check("result", result, lk ? 0 : e.r);
        check("carry", carry, lk ? 0 : e.c);
        check("zero", zero, lk ? 0 : e.z);
        check("overflow", overflow, lk ? 0 : e.v);
        check("alarm", alarm, m_alarm);
        check("mismatch_cnt", mismatch_cnt, m_cnt);
      end
    end
    if (clr) begin m_alarm = 1'b0; m_cnt = 0; end
    if (acc) sb.push_back(model(a, b, o, inj));
    @(posedge clk);
  endtask

  task automatic do_op(input string tag, input int a, input int b, input int o, input bit inj);
    bit acc;
    cycle(1, a, b, o, inj, 1, 0, acc);
    check({tag, "_accept"}, acc, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    check({tag, "_lat1"}, last_ov, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    check({tag, "_lat2"}, last_ov, 1);
  endtask

  task automatic clear_alarm();
    bit acc;
    cycle(0, 0, 0, 0, 0, 1, 1, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    check("clr_alarm", last_alarm, 0);
    check("clr_cnt", last_cnt, 0);
  endtask

  task automatic drain(input string tag);
    bit acc;
    for (int i = 0; i < 40 && sb.size() > 0; i++) cycle(0, 0, 0, 0, 0, 1, 0, acc);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k, first_low, out0;
    int ops4[4];

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_alarm", alarm, 0);
    check("rst_cnt", mismatch_cnt, 0);
    rst_n = 1'b1;

    do_op("add_ff_01", 8'hFF, 8'h01, 0, 0);
    check("add_ff_01_res", last_res, 8'h00);
    check("add_ff_01_c", last_c, 1);
    check("add_ff_01_z", last_z, 1);
    check("add_ff_01_v", last_v, 0);

    do_op("sub_80_01", 8'h80, 8'h01, 1, 0);
    check("sub_80_01_res", last_res, 8'h7F);
    check("sub_80_01_c", last_c, 1);
    check("sub_80_01_v", last_v, 1);
    do_op("sub_01_02", 8'h01, 8'h02, 1, 0);
    check("sub_01_02_res", last_res, 8'hFF);
    check("sub_01_02_c", last_c, 0);

    do_op("and_inj", 8'h0F, 8'hF0, 2, 1);
    check("and_inj_alarm", last_alarm, 1);
    check("and_inj_cnt", last_cnt, 1);
    check("and_inj_res", last_res, 8'h00);
    do_op("locked_add", 8'h03, 8'h04, 0, 0);
    check("locked_res", last_res, 8'h00);
    check("locked_flags", {last_c, last_z, last_v}, 3'b000);

    clear_alarm();
    do_op("xor_aa_55", 8'hAA, 8'h55, 4, 0);
    check("xor_aa_55_res", last_res, 8'hFF);
    check("xor_aa_55_alarm", last_alarm, 0);

    do_op("inj_a", 8'h11, 8'h22, 0, 1);
    do_op("inj_b", 8'h33, 8'h01, 6, 1);
    check("two_inj_cnt", last_cnt, 2);
    cycle(1, 8'h01, 8'h02, 0, 1, 1, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 1, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, acc);
    check("clr_vs_mismatch_alarm", last_alarm, 1);
    check("clr_vs_mismatch_cnt", last_cnt, 1);
    clear_alarm();

    // Four back-to-back ops with the sink stalled for three cycles.
    ops4[0] = 0; ops4[1] = 1; ops4[2] = 4; ops4[3] = 6;
    k = 0; first_low = -1; out0 = n_out;
    for (int j = 0; j < 20 && k < 4; j++) begin
      cycle(1, 16 * k + 9, 3 * k + 2, ops4[k], 0, !(j >= 1 && j <= 3), 0, acc);
      if (acc) k++;
      else if (first_low < 0) first_low = k;
    end
    check("stall_ops_accepted", k, 4);
    check("stall_inready_drop_after", first_low, 2);
    drain("stall_drain");
    check("stall_outputs", n_out - out0, 4);

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), (i >= 200) && ($urandom_range(0, 15) == 0),
            $urandom_range(0, 2) != 0, 0, acc);
    end
    drain("random_drain");

    clear_alarm();
    for (int i = 0; i < 260; i++)
      cycle(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), 1, 1, 0, acc);
    drain("sat_drain");
    @(negedge clk); #1;
    check("cnt_saturated", mismatch_cnt, 8'hFF);
    check("sat_alarm", alarm, 1);

    cycle(1, 5, 6, 0, 0, 0, 0, acc);
    cycle(1, 7, 8, 1, 0, 0, 0, acc);
    check("fill_second_accept", acc, 1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("full_out_valid", out_valid, 1);
    rst_n = 1'b0; #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_alarm", alarm, 0);
    check("async_rst_cnt", mismatch_cnt, 0);
    check("async_rst_result", result, 0);
    sb.delete(); m_alarm = 1'b0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 1, 0, acc);
    check("no_output_after_reset", n_out - out0, 0);
    do_op("or_after_reset", 8'h12, 8'h34, 3, 0);
    check("or_after_reset_res", last_res, 8'h36);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
